key_debounce: RTL

- Input-conditioning stage sitting directly upstream of the vending-machine top-level FSM and its compute module.
- Takes raw mechanical push-button levels (signal, cancel_flag, one, ten, high, low, refresh) and produces clean, synchronised, debounced levels plus single-cycle press pulses.
- The FSM therefore sees exactly one event per physical press, and the coin counter's edge-triggered logic no longer counts contact bounce.
- One instance serves all front-panel keys.

---
 rtl/key_debounce_pkg.sv | 20 ++
 rtl/key_debounce_if.sv | 22 ++
 rtl/key_debounce_filter.sv | 124 ++++++++++++
 rtl/key_debounce.sv | 69 ++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the front-panel key conditioning slice:
// per-channel debounce state encoding and panel key indices.
package key_pkg;

   typedef logic [1:0] key_state_t;

   localparam key_state_t IDLE         = 2'd0;
   localparam key_state_t PRESS_WAIT   = 2'd1;
   localparam key_state_t PRESSED      = 2'd2;
   localparam key_state_t RELEASE_WAIT = 2'd3;

   localparam int unsigned KEY_SIGNAL  = 0;
   localparam int unsigned KEY_CANCEL  = 1;
   localparam int unsigned KEY_ONE     = 2;
   localparam int unsigned KEY_TEN     = 3;
   localparam int unsigned KEY_HIGH    = 4;
   localparam int unsigned KEY_LOW     = 5;
   localparam int unsigned KEY_REFRESH = 6;

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle between the raw front panel and the vending FSM.
// master = debouncer (consumes raw levels), slave = panel/consumer side.
interface key_debounce_if #(
   parameter int unsigned N_KEYS = 7
);
   logic [N_KEYS-1:0] key_raw;
   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] key_pulse;
   logic              key_valid;
   logic [2:0]        key_code;
   logic              multi_press;

   modport master (
      input  key_raw,
      output key_level, key_pulse, key_valid, key_code, multi_press
   );

   modport slave (
      output key_raw,
      input  key_level, key_pulse, key_valid, key_code, multi_press
   );
endinterface

// File: rtl/key_debounce_filter.sv
// One key channel: 2-flop synchroniser, debounce FSM with qualification counter,
// and (with KEY_REPEAT_EN defined) an auto-repeat counter active while held.
module key_filter
   import key_pkg::*;
#(
   parameter int unsigned CNT_W           = 20,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
`ifdef KEY_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_level,
   output logic key_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_d;
   logic             sync_q;
   key_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             press_pulse;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_d <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         sync_d <= key_raw;
         sync_q <= sync_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         key_level   <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         press_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (sync_q) begin
                  cnt   <= '0;
                  state <= PRESS_WAIT;
               end
            end
            PRESS_WAIT: begin
               if (!sync_q) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  cnt         <= '0;
                  state       <= PRESSED;
                  key_level   <= 1'b1;
                  press_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!sync_q) begin
                  cnt   <= '0;
                  state <= RELEASE_WAIT;
               end
            end
            RELEASE_WAIT: begin
               // a bounce back to high returns to PRESSED silently
               if (sync_q) begin
                  cnt   <= '0;
                  state <= PRESSED;
               end else if (cnt == CNT_LAST) begin
                  cnt       <= '0;
                  state     <= IDLE;
                  key_level <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef KEY_REPEAT_EN
   logic [31:0] rep_cnt;
   logic        rep_run;
   logic        rep_pulse;

   // rep_run selects the period limit once the initial delay has elapsed
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt   <= '0;
         rep_run   <= 1'b0;
         rep_pulse <= 1'b0;
      end else begin
         rep_pulse <= 1'b0;
         if (state == PRESSED && sync_q) begin
            if (rep_cnt == (rep_run ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1))) begin
               rep_pulse <= 1'b1;
               rep_cnt   <= '0;
               rep_run   <= 1'b1;
            end else begin
               rep_cnt <= rep_cnt + 32'd1;
            end
         end else begin
            rep_cnt <= '0;
            rep_run <= 1'b0;
         end
      end
   end

   assign key_pulse = press_pulse | rep_pulse;
`else
   assign key_pulse = press_pulse;
`endif

endmodule

// File: rtl/key_debounce.sv
// Front-panel key conditioner: N_KEYS independent debounce channels plus a
// registered encoder (valid / lowest index / multi-press). Option: KEY_REPEAT_EN.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned N_KEYS          = 7,
   parameter int unsigned CNT_W           = 20,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic           clk,
   input  logic           reset,
   key_debounce_if.master kif
);

   if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W) ||
       REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_params
      $error("key_debounce: timing parameters out of range");
   end

   logic [N_KEYS-1:0] pulse;
   logic [2:0]        code_next;
   logic              code_found;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_filter #(
         .CNT_W          (CNT_W),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
         ,
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
      ) u_filter (
         .clk      (clk),
         .reset    (reset),
         .key_raw  (kif.key_raw[i]),
         .key_level(kif.key_level[i]),
         .key_pulse(pulse[i])
      );
   end

   assign kif.key_pulse = pulse;

   always_comb begin
      code_next  = '0;
      code_found = 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
         if (pulse[i] && !code_found) begin
            code_next  = 3'(i);
            code_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kif.key_valid   <= 1'b0;
         kif.key_code    <= '0;
         kif.multi_press <= 1'b0;
      end else begin
         kif.key_valid   <= |pulse;
         kif.key_code    <= code_next;
         kif.multi_press <= ($countones(pulse) > 1);
      end
   end

endmodule
